// File: rtl/mbist_controller.sv
// March-style memory BIST sequencer: for each of six decoder patterns it
// writes every word, reads every word back and compares against the pattern.
// The first miscompare is latched as fail/fail_q/fail_addr.
// Optional feature: define MBIST_STOP_ON_FAIL_EN to end the run at the first failure.
module mbist_controller #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [2:0]        q,
    input  logic [7:0]        data_t,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              re,
    input  logic [7:0]        data_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [2:0]        fail_q,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [2:0]        Q_LAST    = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        q_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              we_nx;
    logic              re_nx;
    logic              busy_nx;
    logic              done_nx;
    logic              launch_c;

    // Read-compare pipeline: expected data, pattern and address ride one cycle behind re.
    logic              cmp_vld;
    logic [7:0]        cmp_exp;
    logic [2:0]        cmp_q;
    logic [ADDR_W-1:0] cmp_addr;
    logic              miscmp_c;

    assign launch_c = ((state == IDLE) || (state == DONE)) && start;
    assign miscmp_c = cmp_vld && (data_out != cmp_exp);

    // State and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= 3'd0;
            addr  <= '0;
            we    <= 1'b0;
            re    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            addr  <= addr_nx;
            we    <= we_nx;
            re    <= re_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next-state sequencing; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        addr_nx  = addr;
        we_nx    = 1'b0;
        re_nx    = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = WRITE;
                    q_nx     = 3'd0;
                    addr_nx  = '0;
                end
            end
            WRITE: begin
                if (addr == ADDR_LAST) begin
                    state_nx = READ;
                    addr_nx  = '0;
                end else begin
                    addr_nx = addr + ADDR_W'(1);
                end
            end
            READ: begin
                if (addr == ADDR_LAST) begin
                    state_nx = DRAIN;
                    addr_nx  = '0;
                end else begin
                    addr_nx = addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (q == Q_LAST) begin
                    state_nx = DONE;
                end else begin
                    state_nx = WRITE;
                    q_nx     = q + 3'd1;
                    addr_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                q_nx     = 3'd0;
                addr_nx  = '0;
            end
        endcase

`ifdef MBIST_STOP_ON_FAIL_EN
        // A latched failure abandons the remaining sweeps, keeping q where it failed.
        if (fail && ((state == WRITE) || (state == READ) || (state == DRAIN))) begin
            state_nx = DONE;
            q_nx     = q;
            addr_nx  = addr;
        end
`endif

        we_nx   = (state_nx == WRITE);
        re_nx   = (state_nx == READ);
        busy_nx = (state_nx == WRITE) || (state_nx == READ) || (state_nx == DRAIN);
        done_nx = (state_nx == DONE);
    end

    // Delay expected data and location so they line up with data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld  <= 1'b0;
            cmp_exp  <= 8'h00;
            cmp_q    <= 3'd0;
            cmp_addr <= '0;
        end else begin
            cmp_vld  <= re;
            cmp_exp  <= data_t;
            cmp_q    <= q;
            cmp_addr <= addr;
        end
    end

    // Sticky first-failure capture, cleared when a new run launches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_q    <= 3'd0;
            fail_addr <= '0;
        end else if (launch_c) begin
            fail      <= 1'b0;
            fail_q    <= 3'd0;
            fail_addr <= '0;
        end else if (miscmp_c && !fail) begin
            fail      <= 1'b1;
            fail_q    <= cmp_q;
            fail_addr <= cmp_addr;
        end
    end

endmodule
